// File: rtl/crossbar_rr_pkg.sv
// Shared packet type and width helpers for the round-robin packet crossbar.
package crossbar_rr_pkg;

  localparam int unsigned MaxNodes = 16;
  localparam int unsigned SrcW     = 4;
  // One bit wider than a node index so out-of-range destinations stay distinguishable.
  localparam int unsigned DestW    = 5;
  localparam int unsigned PayloadW = 16;

  typedef struct packed {
    logic [SrcW-1:0]     src;
    logic [DestW-1:0]    dest;
    logic [PayloadW-1:0] payload;
  } pkt_t;

  // Index width for n entries (NODE_W); never zero so single-bit selects stay legal.
  function automatic int unsigned node_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crossbar_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past the winner.
module crossbar_rr_arbiter
  import crossbar_rr_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt_onehot,
  output logic [node_w(N)-1:0] gnt_idx,
  output logic                 any_gnt
);

  localparam int unsigned IdxW = node_w(N);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW:0]   cand;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_gnt    = 1'b0;
    cand       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(N)) begin
        cand = cand - (IdxW+1)'(N);
      end
      if (!any_gnt && req[cand[IdxW-1:0]]) begin
        any_gnt                     = 1'b1;
        gnt_idx                     = cand[IdxW-1:0];
        gnt_onehot[cand[IdxW-1:0]] = 1'b1;
      end
    end
  end

  // Explicit wrap so non-power-of-two node counts rotate correctly.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && any_gnt) begin
      ptr_d = (gnt_idx == IdxW'(N - 1)) ? '0 : gnt_idx + IdxW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/crossbar_rr.sv
// N x N packet crossbar: per-input FIFOs, per-output round-robin arbiters and registered
// valid/ready output slots; heads with an out-of-range destination are dropped and counted.
module crossbar_rr
  import crossbar_rr_pkg::*;
#(
  parameter int unsigned NUM_NODES  = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  pkt_t [NUM_NODES-1:0]       pkt_in,
  input  logic [NUM_NODES-1:0]       pkt_in_valid,
  output logic [NUM_NODES-1:0]       pkt_in_ready,
  output pkt_t [NUM_NODES-1:0]       pkt_out,
  output logic [NUM_NODES-1:0]       pkt_out_valid,
  input  logic [NUM_NODES-1:0]       pkt_out_ready,
  output logic [CNT_W-1:0]           drop_count
);

  localparam int unsigned IdxW  = node_w(NUM_NODES);
  localparam int unsigned PtrW  = node_w(FIFO_DEPTH);
  localparam int unsigned CntFW = PtrW + 1;

  pkt_t                 head      [NUM_NODES];
  logic [NUM_NODES-1:0] gnt_by_in [NUM_NODES];
  logic [NUM_NODES-1:0] empty, full, push, pop, bad;

  for (genvar i = 0; i < NUM_NODES; i++) begin : g_fifo
    pkt_t             mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [CntFW-1:0] cnt_q;

    assign empty[i]        = (cnt_q == '0);
    assign full[i]         = (cnt_q == CntFW'(FIFO_DEPTH));
    assign pkt_in_ready[i] = ~full[i];
    assign push[i]         = pkt_in_valid[i] & ~full[i];
    assign head[i]         = mem_q[rd_q];
    assign bad[i]          = ~empty[i] & (head[i].dest >= DestW'(NUM_NODES));
    // At most one output can claim a given head, so pops never double up.
    assign pop[i]          = (|gnt_by_in[i]) | bad[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push[i]) wr_q <= wr_q + PtrW'(1);
        if (pop[i])  rd_q <= rd_q + PtrW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt_q <= cnt_q + CntFW'(1);
          2'b01:   cnt_q <= cnt_q - CntFW'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push[i]) mem_q[wr_q] <= pkt_in[i];
    end
  end

  for (genvar o = 0; o < NUM_NODES; o++) begin : g_out
    logic [NUM_NODES-1:0] req_o, gnt_raw, gnt_o;
    logic [IdxW-1:0]      gnt_idx_o;
    logic                 any_o, free_o, valid_q;
    pkt_t                 out_q;

    for (genvar i = 0; i < NUM_NODES; i++) begin : g_req
      assign req_o[i]        = ~empty[i] & (head[i].dest == DestW'(o));
      assign gnt_by_in[i][o] = gnt_o[i];
    end

    assign free_o = ~valid_q | pkt_out_ready[o];
    assign gnt_o  = gnt_raw & {NUM_NODES{free_o}};

    crossbar_rr_arbiter #(
      .N(NUM_NODES)
    ) u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        (req_o),
      .advance    (free_o),
      .gnt_onehot (gnt_raw),
      .gnt_idx    (gnt_idx_o),
      .any_gnt    (any_o)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        out_q   <= '0;
      end else if (free_o && any_o) begin
        valid_q <= 1'b1;
        out_q   <= head[gnt_idx_o];
      end else if (pkt_out_ready[o]) begin
        valid_q <= 1'b0;
      end
    end

    assign pkt_out[o]       = out_q;
    assign pkt_out_valid[o] = valid_q;
  end

  logic [CNT_W-1:0] drop_q;
  logic [CNT_W:0]   drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_q} + (CNT_W+1)'($countones(bad));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (|bad) begin
      drop_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

  assign drop_count = drop_q;

endmodule

// File: tb/tb_crossbar_rr.sv
// Bench for crossbar_rr: directed table and corner sequences plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_crossbar_rr;
  import crossbar_rr_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 16;

  logic           clk = 1'b0;
  logic           rst;
  pkt_t [N-1:0]   pkt_in;
  logic [N-1:0]   pkt_in_valid, pkt_in_ready;
  pkt_t [N-1:0]   pkt_out;
  logic [N-1:0]   pkt_out_valid, pkt_out_ready;
  logic [CW-1:0]  drop_count;

  crossbar_rr #(
    .NUM_NODES  (N),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_in        (pkt_in),
    .pkt_in_valid  (pkt_in_valid),
    .pkt_in_ready  (pkt_in_ready),
    .pkt_out       (pkt_out),
    .pkt_out_valid (pkt_out_valid),
    .pkt_out_ready (pkt_out_ready),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain queues per input, one slot per output, rotating start index.
  pkt_t     mq [N][$];
  logic     m_valid [N];
  pkt_t     m_out [N];
  int       m_ptr [N];
  int       m_drop;

  typedef struct {
    int         src;
    int         dest;
    int         payload;
    logic [3:0] exp_valid;
    int         exp_drop;
  } vec_t;

  function automatic pkt_t mkpkt(input int s, input int d, input int p);
    pkt_t r;
    r.src     = SrcW'(s);
    r.dest    = DestW'(d);
    r.payload = PayloadW'(p);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_valid[i] = 1'b0;
      m_out[i]   = '0;
      m_ptr[i]   = 0;
    end
    m_drop = 0;
  endtask

  task automatic model_step();
    bit   acc [N];
    bit   popi [N];
    int   win [N];
    int   ndrop;
    ndrop = 0;
    for (int i = 0; i < N; i++) begin
      acc[i]  = pkt_in_valid[i] && (mq[i].size() < DEPTH);
      popi[i] = 1'b0;
      if (mq[i].size() > 0 && int'(mq[i][0].dest) >= N) begin
        popi[i] = 1'b1;
        ndrop++;
      end
    end
    for (int o = 0; o < N; o++) begin
      win[o] = -1;
      if (!m_valid[o] || pkt_out_ready[o]) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr[o] + k) % N;
          if (win[o] < 0 && mq[c].size() > 0 && int'(mq[c][0].dest) == o) win[o] = c;
        end
      end
    end
    for (int o = 0; o < N; o++) begin
      if (win[o] >= 0) begin
        m_out[o]      = mq[win[o]][0];
        m_valid[o]    = 1'b1;
        m_ptr[o]      = (win[o] + 1) % N;
        popi[win[o]]  = 1'b1;
      end else if (pkt_out_ready[o]) begin
        m_valid[o] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (popi[i]) void'(mq[i].pop_front());
      if (acc[i])  mq[i].push_back(pkt_in[i]);
    end
    m_drop = m_drop + ndrop;
    if (m_drop > (1 << CW) - 1) m_drop = (1 << CW) - 1;
  endtask

  task automatic compare();
    logic [N-1:0] ev, er;
    for (int i = 0; i < N; i++) begin
      ev[i] = m_valid[i];
      er[i] = (mq[i].size() < DEPTH);
    end
    chk("out_valid", 32'(pkt_out_valid), 32'(ev));
    chk("in_ready", 32'(pkt_in_ready), 32'(er));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    for (int o = 0; o < N; o++) chk("pkt_out", 32'(pkt_out[o]), 32'(m_out[o]));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    pkt_in_valid = '0;
    pkt_in       = '0;
  endtask

  task automatic apply_reset();
    idle();
    pkt_out_ready = '1;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare();
  endtask

  task automatic test_table();
    vec_t vecs [8];
    vecs[0] = '{0, 2, 'h1234, 4'b0100, 0};
    vecs[1] = '{1, 0, 'h0bad, 4'b0001, 0};
    vecs[2] = '{3, 3, 'hbeef, 4'b1000, 0};
    vecs[3] = '{2, 5, 'h5555, 4'b0000, 1};
    vecs[4] = '{2, 1, 'h2222, 4'b0010, 1};
    vecs[5] = '{1, 31, 'h7777, 4'b0000, 2};
    vecs[6] = '{0, 4, 'h4444, 4'b0000, 3};
    vecs[7] = '{3, 0, 'hcafe, 4'b0001, 3};
    apply_reset();
    chk("rst_valid", 32'(pkt_out_valid), 0);
    chk("rst_ready", 32'(pkt_in_ready), 32'hf);
    chk("rst_drop", 32'(drop_count), 0);
    for (int v = 0; v < 8; v++) begin
      pkt_in[vecs[v].src]       = mkpkt(vecs[v].src, vecs[v].dest, vecs[v].payload);
      pkt_in_valid[vecs[v].src] = 1'b1;
      step();
      idle();
      chk("tbl_lat1", 32'(pkt_out_valid), 0);
      step();
      chk("tbl_valid", 32'(pkt_out_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid != 4'b0000) begin
        chk("tbl_pkt", 32'(pkt_out[vecs[v].dest]),
            32'(mkpkt(vecs[v].src, vecs[v].dest, vecs[v].payload)));
      end
      chk("tbl_drop", 32'(drop_count), 32'(vecs[v].exp_drop));
      step();
      chk("tbl_consumed", 32'(pkt_out_valid), 0);
    end
  endtask

  task automatic test_fair();
    int srcs [$];
    int first, last;
    first = -1;
    last  = -1;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      if (c < 3) begin
        for (int i = 0; i < N; i++) pkt_in[i] = mkpkt(i, 1, c);
        pkt_in_valid = '1;
      end else begin
        idle();
      end
      step();
      if (pkt_out_valid[1]) begin
        srcs.push_back(int'(pkt_out[1].src));
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("fair_count", 32'(srcs.size()), 12);
    chk("fair_gapless", 32'(last - first), 11);
    for (int k = 0; k < srcs.size(); k++) chk("fair_order", 32'(srcs[k]), 32'(k % 4));
  endtask

  task automatic test_backpressure();
    int got [$];
    apply_reset();
    pkt_out_ready = 4'b0111;
    for (int k = 0; k < 9; k++) begin
      pkt_in[0]    = mkpkt(0, 3, k);
      pkt_in_valid = 4'b0001;
      step();
    end
    chk("bp_full", 32'(pkt_in_ready[0]), 0);
    chk("bp_held", 32'(pkt_out_valid[3]), 1);
    pkt_in[0] = mkpkt(0, 3, 9);
    step();
    chk("bp_refused", 32'(pkt_in_ready[0]), 0);
    idle();
    pkt_out_ready = '1;
    if (pkt_out_valid[3]) got.push_back(int'(pkt_out[3].payload));
    for (int c = 0; c < 12; c++) begin
      step();
      if (pkt_out_valid[3]) got.push_back(int'(pkt_out[3].payload));
    end
    chk("bp_count", 32'(got.size()), 9);
    for (int k = 0; k < got.size(); k++) chk("bp_order", 32'(got[k]), 32'(k));
  endtask

  task automatic test_parallel();
    int perm [4];
    perm = '{2, 3, 0, 1};
    apply_reset();
    for (int i = 0; i < N; i++) pkt_in[i] = mkpkt(i, perm[i], 'h50 + i);
    pkt_in_valid = '1;
    step();
    idle();
    chk("par_lat1", 32'(pkt_out_valid), 0);
    step();
    chk("par_all", 32'(pkt_out_valid), 32'hf);
    for (int i = 0; i < N; i++) chk("par_src", 32'(pkt_out[perm[i]].src), 32'(i));
  endtask

  task automatic test_async_reset();
    apply_reset();
    pkt_out_ready = 4'b1110;
    pkt_in[1]       = mkpkt(1, 6, 'h66);
    pkt_in_valid[1] = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) pkt_in[i] = mkpkt(i, 0, 'h100 + c);
      pkt_in_valid = '1;
      step();
    end
    idle();
    chk("mid_drop", 32'(drop_count), 1);
    chk("mid_valid0", 32'(pkt_out_valid[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(pkt_out_valid), 0);
    chk("arst_drop", 32'(drop_count), 0);
    chk("arst_ready", 32'(pkt_in_ready), 32'hf);
    chk("arst_pkt0", 32'(pkt_out[0]), 0);
    model_reset();
    #2 rst = 1'b0;
    pkt_in[2]       = mkpkt(2, 3, 'h77);
    pkt_in_valid[2] = 1'b1;
    step();
    idle();
    chk("arst_lat1", 32'(pkt_out_valid), 0);
    step();
    chk("arst_lat2", 32'(pkt_out_valid), 32'h8);
    chk("arst_pkt", 32'(pkt_out[3]), 32'(mkpkt(2, 3, 'h77)));
  endtask

  task automatic test_random();
    int rdy_pct;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy_pct = ((c / 500) % 2 == 0) ? 80 : 30;
      for (int i = 0; i < N; i++) begin
        int d;
        d = ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 31)) : int'($urandom_range(0, 3));
        pkt_in[i]        = mkpkt(i, d, int'($urandom_range(0, 65535)));
        pkt_in_valid[i]  = ($urandom_range(0, 1) == 1);
        pkt_out_ready[i] = (int'($urandom_range(0, 99)) < rdy_pct);
      end
      step();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    pkt_out_ready = '1;
    model_reset();
    test_table();
    test_fair();
    test_backpressure();
    test_parallel();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
